// File: rtl/md_pkg.sv
// Shared types and defaults for the multiply/divide scheduler.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'd0,
    MD_MULT  = 2'd1,
    MD_DIVU  = 2'd2,
    MD_DIV   = 2'd3
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MD_MULT_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF  = 10;
  localparam int MD_CNT_W        = 5;

endpackage

// File: rtl/md_sched_if.sv
// E-stage request/response bundle between the pipeline and md_sched.
interface md_sched_if;
  logic        start;
  logic [1:0]  op;
  logic        mdwe;
  logic        hilo;
  logic        mf;
  logic        mdread;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] wdata;
  logic        cancel;
  logic        busy;
  logic        stall;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, mdwe, hilo, mf, mdread, rs_val, rt_val, wdata, cancel,
    input  busy, stall, md_out, hi, lo
  );

  modport slave (
    input  start, op, mdwe, hilo, mf, mdread, rs_val, rt_val, wdata, cancel,
    output busy, stall, md_out, hi, lo
  );
endinterface

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath. res = {HI, LO}.
// Signed divide works on magnitudes so that 0x80000000 / -1 needs no
// special case: the unsigned quotient 0x80000000 is already the answer.
module md_alu
  import md_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div_zero
);

  logic        sgn;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_val, r_val;

  assign sgn   = (op == MD_DIV);
  assign a_mag = (sgn && a[31]) ? (32'd0 - a) : a;
  assign b_mag = (sgn && b[31]) ? (32'd0 - b) : b;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign q_val = (sgn && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
  assign r_val = (sgn && a[31]) ? (32'd0 - r_mag) : r_mag;

  // Select product or {remainder, quotient}; flag a zero divisor
  always_comb begin
    res      = '0;
    div_zero = 1'b0;
    case (op)
      MD_MULTU: res = {32'd0, a} * {32'd0, b};
      MD_MULT:  res = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      default: begin
        res      = {r_val, q_val};
        div_zero = (b == 32'd0);
      end
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// HI/LO multiply/divide scheduler with fixed-latency busy window.
// Optional build macro MD_CANCEL_EN: cancel aborts an in-flight operation
// and blocks acceptance; without it the cancel input is ignored.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no operation in flight; start/mthi/mtlo accepted
// ST_BUSY | counter running; HI/LO written when it reaches 1
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_LAT = MD_MULT_LAT_DEF,
  parameter int DIV_LAT  = MD_DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  bus
);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  md_op_e                op_q;
  logic [31:0]           a_q, b_q, hi_q, lo_q;
  logic                  load, done, mdwe_acc, cancel_act, div_zero;
  logic [63:0]           alu_res;

`ifdef MD_CANCEL_EN
  assign cancel_act = bus.cancel;
`else
  assign cancel_act = 1'b0;
`endif

  // A start in IDLE always beats a simultaneous mthi/mtlo
  assign mdwe_acc = (state_q == ST_IDLE) && bus.mdwe && !bus.start;

  // Next state, counter and load/complete strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !cancel_act) begin
          state_d = ST_BUSY;
          load    = 1'b1;
          cnt_d   = (bus.op[1]) ? MD_CNT_W'(DIV_LAT) : MD_CNT_W'(MULT_LAT);
        end
      end
      ST_BUSY: begin
        if (cancel_act) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == MD_CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q - MD_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and countdown registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand capture on an accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= MD_MULTU;
      a_q  <= '0;
      b_q  <= '0;
    end else if (load) begin
      op_q <= md_op_e'(bus.op);
      a_q  <= bus.rs_val;
      b_q  <= bus.rt_val;
    end
  end

  md_alu u_alu (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .res      (alu_res),
    .div_zero (div_zero)
  );

  // Architectural HI/LO: completion result or mthi/mtlo data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done) begin
      if (!div_zero) begin
        hi_q <= alu_res[63:32];
        lo_q <= alu_res[31:0];
      end
    end else if (mdwe_acc) begin
      if (bus.hilo) hi_q <= bus.wdata;
      else          lo_q <= bus.wdata;
    end
  end

  assign bus.busy   = (state_q == ST_BUSY);
  assign bus.stall  = bus.busy && (bus.start || bus.mf || bus.mdwe);
  assign bus.md_out = bus.mdread ? lo_q : hi_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed test for md_sched with default latencies (mult 5, div 10).
module tb_md_sched;
  import md_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  md_sched_if bus();

  md_sched #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at the current negedge, drop start, count busy cycles.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nb);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    @(negedge clk);
    bus.start = 1'b0;
    nb = 0;
    while (bus.busy === 1'b1 && nb < 64) begin
      nb++;
      @(negedge clk);
    end
  endtask

  int nb;

  initial begin
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 2'd0;
    bus.mdwe   = 1'b0;
    bus.hilo   = 1'b0;
    bus.mf     = 1'b0;
    bus.mdread = 1'b0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.wdata  = '0;
    bus.cancel = 1'b0;

    @(negedge clk);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_hi",    bus.hi, 32'd0);
    chk("rst_lo",    bus.lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(2'd1, 32'hFFFF_FFFF, 32'h2, nb);
    chk("mult_busy", 32'(nb), 32'd5);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFE);

    run_op(2'd0, 32'hFFFF_FFFF, 32'h2, nb);
    chk("multu_busy", 32'(nb), 32'd5);
    chk("multu_hi", bus.hi, 32'h1);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

    run_op(2'd3, 32'hFFFF_FFF9, 32'h2, nb);
    chk("div_busy", 32'(nb), 32'd10);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    run_op(2'd2, 32'h7, 32'h0, nb);
    chk("divz_busy", 32'(nb), 32'd10);
    chk("divz_lo", bus.lo, 32'hFFFF_FFFD);
    chk("divz_hi", bus.hi, 32'hFFFF_FFFF);

    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    chk("divovf_lo", bus.lo, 32'h8000_0000);
    chk("divovf_hi", bus.hi, 32'h0);

    run_op(2'd3, 32'h7, 32'hFFFF_FFFE, nb);
    chk("div_7_m2_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_7_m2_hi", bus.hi, 32'h1);

    run_op(2'd2, 32'd100, 32'd7, nb);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);

    // mf held through a busy window: stall every busy cycle
    bus.start  = 1'b1;
    bus.op     = 2'd0;
    bus.rs_val = 32'd3;
    bus.rt_val = 32'd4;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mf     = 1'b1;
    bus.mdread = 1'b1;
    nb = 0;
    while (bus.busy === 1'b1 && nb < 64) begin
      chk("mf_stall_busy", 32'(bus.stall), 32'd1);
      nb++;
      @(negedge clk);
    end
    chk("mf_busy_len", 32'(nb), 32'd5);
    chk("mf_stall_idle", 32'(bus.stall), 32'd0);
    chk("mf_md_out_lo", bus.md_out, 32'd12);
    bus.mf = 1'b0;

    // mthi in IDLE
    bus.mdwe  = 1'b1;
    bus.hilo  = 1'b1;
    bus.wdata = 32'h1234;
    @(negedge clk);
    bus.mdwe = 1'b0;
    chk("mthi_hi", bus.hi, 32'h1234);
    chk("mthi_lo", bus.lo, 32'd12);
    bus.mdread = 1'b0;
    #1;
    chk("mfhi_out", bus.md_out, 32'h1234);

    // start together with mtlo: only the operation runs
    bus.start  = 1'b1;
    bus.op     = 2'd0;
    bus.rs_val = 32'd2;
    bus.rt_val = 32'd3;
    bus.mdwe   = 1'b1;
    bus.hilo   = 1'b0;
    bus.wdata  = 32'hDEAD;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mdwe  = 1'b0;
    chk("smdwe_lo_kept", bus.lo, 32'd12);
    chk("smdwe_busy", 32'(bus.busy), 32'd1);
    nb = 1;
    @(negedge clk);
    while (bus.busy === 1'b1 && nb < 64) begin
      nb++;
      @(negedge clk);
    end
    chk("smdwe_len", 32'(nb), 32'd5);
    chk("smdwe_hi", bus.hi, 32'd0);
    chk("smdwe_lo", bus.lo, 32'd6);

    // back-to-back: second start held through stall, taken when busy falls
    bus.start  = 1'b1;
    bus.op     = 2'd0;
    bus.rs_val = 32'd5;
    bus.rt_val = 32'd5;
    @(negedge clk);
    bus.op     = 2'd1;
    bus.rs_val = 32'hFFFF_FFFF;
    bus.rt_val = 32'd3;
    nb = 0;
    while (bus.busy === 1'b1 && nb < 64) begin
      chk("b2b_stall", 32'(bus.stall), 32'd1);
      nb++;
      @(negedge clk);
    end
    chk("b2b_first_len", 32'(nb), 32'd5);
    chk("b2b_first_lo", bus.lo, 32'd25);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_second_busy", 32'(bus.busy), 32'd1);
    nb = 1;
    @(negedge clk);
    while (bus.busy === 1'b1 && nb < 64) begin
      nb++;
      @(negedge clk);
    end
    chk("b2b_second_len", 32'(nb), 32'd5);
    chk("b2b_second_hi", bus.hi, 32'hFFFF_FFFF);
    chk("b2b_second_lo", bus.lo, 32'hFFFF_FFFD);

    // reset pulse in the third busy cycle of a divide
    bus.start  = 1'b1;
    bus.op     = 2'd3;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_hi", bus.hi, 32'd0);
    chk("rstmid_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("rstmid_after_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_after_lo", bus.lo, 32'd0);

`ifdef MD_CANCEL_EN
    // cancel in the final busy cycle wins over completion
    bus.start  = 1'b1;
    bus.op     = 2'd0;
    bus.rs_val = 32'd3;
    bus.rt_val = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel_busy", 32'(bus.busy), 32'd0);
    chk("cancel_lo", bus.lo, 32'd0);
    repeat (3) @(negedge clk);
    chk("cancel_lo_late", bus.lo, 32'd0);
    // cancel with start in IDLE blocks acceptance
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    chk("cancel_block", 32'(bus.busy), 32'd0);
`else
    // cancel is ignored: operation completes normally
    bus.start  = 1'b1;
    bus.op     = 2'd0;
    bus.rs_val = 32'd3;
    bus.rt_val = 32'd3;
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    nb = 0;
    while (bus.busy === 1'b1 && nb < 64) begin
      nb++;
      @(negedge clk);
    end
    bus.cancel = 1'b0;
    chk("nocancel_len", 32'(nb), 32'd5);
    chk("nocancel_lo", bus.lo, 32'd9);
    chk("nocancel_hi", bus.hi, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 Parameter MULT_LAT, default 5: busy cycles for mult/multu (legal range 1..31).
REQ-002 Parameter DIV_LAT, default 10: busy cycles for div/divu (legal range 1..31).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  E-stage mult/multu/div/divu request.
REQ-006 op  in  2  operation: 0 multu, 1 mult, 2 divu, 3 div.
REQ-007 mdwe  in  1  E-stage mthi/mtlo request.
REQ-008 hilo  in  1  mdwe target: 1 HI, 0 LO.
REQ-009 mf  in  1  E-stage mfhi/mflo request.
REQ-010 mdread  in  1  mf source: 1 LO, 0 HI.
REQ-011 rs_val, rt_val  in  32 each  operands, sampled only on accepted start.
REQ-012 wdata  in  32  mthi/mtlo data.
REQ-013 cancel  in  1  abort the in-flight operation (exception flush).
REQ-014 busy  out  1  operation in flight.
REQ-015 stall  out  1  freeze pipeline at E stage.
REQ-016 md_out  out  32  mfhi/mflo result.
REQ-017 hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-018 FSM states: IDLE, BUSY; busy = (state == BUSY), registered.
REQ-019 IDLE & start: latch operands and op; load counter with MULT_LAT (op 0/1) or DIV_LAT (op 2/3); go to BUSY.
REQ-020 BUSY: counter decrements each cycle; at the edge where counter == 1, write HI/LO and return to IDLE; busy is high for exactly LAT cycles.
REQ-021 start sampled at edge t: busy high in cycles t+1..t+LAT; new hi/lo visible from cycle t+LAT+1.
REQ-022 stall = busy & (start | mf | mdwe), combinational; while stall is high, start and mdwe are not accepted and the requester holds them.
REQ-023 start high in the cycle busy falls is accepted (back-to-back, no bubble).
REQ-024 mult/multu: {HI,LO} = 64-bit signed/unsigned product.
REQ-025 div/divu: LO = quotient, HI = remainder; signed division truncates toward zero; remainder sign follows the dividend.
REQ-026 Divisor zero: HI and LO unchanged; full DIV_LAT busy period still runs.
REQ-027 div 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
REQ-028 mdwe & !busy: wdata written to HI (hilo = 1) or LO (hilo = 0) at the next edge.
REQ-029 start and mdwe asserted together in IDLE: start wins and mdwe is dropped.
REQ-030 md_out = mdread ? lo : hi, combinational; valid only when !busy.

Reset
REQ-031 reset low: asynchronous transition to IDLE; counter = 0; hi = lo = 0; busy = 0; stall = 0.
REQ-032 reset during BUSY: the operation is discarded and no HI/LO write occurs.

Configuration
REQ-033 MD_CANCEL_EN defined: cancel high in BUSY forces IDLE at the next edge with HI/LO unchanged; cancel high with start in IDLE blocks acceptance; cancel has priority over completion in the final cycle.
REQ-034 MD_CANCEL_EN undefined: cancel port present but ignored; operations always run to completion.

Structure
REQ-035 Package md_pkg holds: op encodings (MD_MULTU = 0, MD_MULT = 1, MD_DIVU = 2, MD_DIV = 3), FSM state encoding, default latencies.
REQ-036 Sub-module md_alu, purely combinational: op plus latched operands to a 64-bit result and a divide-by-zero flag; md_sched instantiates it once.

Verification
REQ-037 mult 0xFFFFFFFF x 0x2 -> busy high 5 cycles; then hi = 0xFFFFFFFF, lo = 0xFFFFFFFE; multu with the same operands gives hi = 0x1, lo = 0xFFFFFFFE.
REQ-038 div -7 / 2 -> busy high 10 cycles; then lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; divu 7 / 0 -> hi/lo unchanged.
REQ-039 mf asserted during BUSY -> stall = 1 every busy cycle; after completion, stall = 0 and md_out = new lo (mdread = 1).
REQ-040 mthi 0x1234 in IDLE, then mflo/mfhi -> hi = 0x1234, lo unchanged; start together with mdwe -> only the operation runs.
REQ-041 reset pulse in cycle 3 of a div -> immediate IDLE, hi = lo = 0; MD_CANCEL_EN build with cancel in the last busy cycle -> hi/lo unchanged.
